// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding and board-clock timing constants.
package key_debounce_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;
  localparam int CLK_HZ = 12_000_000;
  localparam int SEC_CYCLES = CLK_HZ;
  localparam int DEBOUNCE_CYCLES_DEF = 240_000;
endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key pins in, conditioned key outputs back.
interface key_debounce_if #(parameter int KEY_NUM = 2);
  logic [KEY_NUM-1:0] key_raw;
  logic [KEY_NUM-1:0] key_level;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_toggle;
  modport master (output key_raw, input key_level, key_press, key_release, key_toggle);
  modport slave (input key_raw, output key_level, key_press, key_release, key_toggle);
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-FF synchronizer, debounce FSM and registered outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic pressed_s, hit;
  key_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic level_n, press_n, release_n, toggle_n;
  // Presetting to the released level keeps reset from looking like a press.
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= {2{KEY_ACTIVE_LOW}};
    else sync <= {sync[0], key_raw};
  assign pressed_s = sync[1] ^ KEY_ACTIVE_LOW;
  assign hit = cnt == TERM;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    level_n = key_level;
    press_n = 1'b0;
    release_n = 1'b0;
    toggle_n = key_toggle;
    case (state)
      IDLE: begin
        state_n = pressed_s ? PRESS_WAIT : IDLE;
        cnt_n = '0;
      end
      PRESS_WAIT: begin
        state_n = !pressed_s ? IDLE : hit ? PRESSED : PRESS_WAIT;
        cnt_n = (!pressed_s || hit) ? '0 : cnt + 1'b1;
        level_n = key_level | (pressed_s & hit);
        press_n = pressed_s & hit;
        toggle_n = key_toggle ^ (pressed_s & hit);
      end
      PRESSED: begin
        state_n = pressed_s ? PRESSED : RELEASE_WAIT;
        cnt_n = '0;
      end
      RELEASE_WAIT: begin
        state_n = pressed_s ? PRESSED : hit ? IDLE : RELEASE_WAIT;
        cnt_n = (pressed_s || hit) ? '0 : cnt + 1'b1;
        level_n = key_level & ~(!pressed_s & hit);
        release_n = !pressed_s & hit;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_toggle <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      key_level <= level_n;
      key_press <= press_n;
      key_release <= release_n;
      key_toggle <= toggle_n;
    end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: KEY_NUM independent debounce channels behind one interface.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int KEY_NUM = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  key_debounce_if.slave bus
);
  logic [KEY_NUM-1:0] level, press, rls, toggle;
  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .key_raw(bus.key_raw[g]),
      .key_level(level[g]),
      .key_press(press[g]),
      .key_release(rls[g]),
      .key_toggle(toggle[g])
    );
  end
  assign bus.key_level = level;
  assign bus.key_press = press;
  assign bus.key_release = rls;
  assign bus.key_toggle = toggle;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random key stimulus scored against a run-length model of debouncing.
module tb_key_debounce;
  localparam int DC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic [1:0] m_lvl = '0, m_tog = '0;
  typedef struct {
    int cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;
  ev_t q[$];
  key_debounce_if #(.KEY_NUM(2)) bus ();
  key_debounce #(.KEY_NUM(2), .DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // A level change is accepted once the pin, seen two clocks late, has differed
  // from the accepted level for DC+1 consecutive samples.
  always @(posedge clk) begin
    static logic h1[2] = '{1'b0, 1'b0};
    static logic h2[2] = '{1'b0, 1'b0};
    static int run[2] = '{0, 0};
    ev_t e;
    cyc++;
    if (rst) begin
      h1 = '{1'b0, 1'b0};
      h2 = '{1'b0, 1'b0};
      run = '{0, 0};
      m_lvl = '0;
      m_tog = '0;
    end else begin
      e.cyc = cyc;
      e.press = '0;
      e.rel = '0;
      for (int c = 0; c < 2; c++) begin
        logic d;
        d = h2[c];
        h2[c] = h1[c];
        h1[c] = ~bus.key_raw[c];
        run[c] = (d != m_lvl[c]) ? run[c] + 1 : 0;
        if (run[c] == DC + 1) begin
          run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            e.press[c] = 1'b1;
            m_tog[c] = ~m_tog[c];
          end else e.rel[c] = 1'b1;
        end
      end
      if (e.press != 0 || e.rel != 0) q.push_back(e);
    end
  end
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (rst) begin
      compared++;
      if ({bus.key_level, bus.key_press, bus.key_release, bus.key_toggle} !== 8'h00) begin
        mismatched++;
        $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b tog=%b want all 0", cyc,
                 bus.key_level, bus.key_press, bus.key_release, bus.key_toggle);
      end
    end else begin
      compared++;
      if (bus.key_level !== m_lvl || bus.key_toggle !== m_tog) begin
        mismatched++;
        $display("FAIL level_toggle cyc=%0d got lvl=%b tog=%b want lvl=%b tog=%b", cyc,
                 bus.key_level, bus.key_toggle, m_lvl, m_tog);
      end
      if (bus.key_press != 0 || bus.key_release != 0 || (q.size() > 0 && q[0].cyc <= cyc)) begin
        e.cyc = cyc;
        e.press = '0;
        e.rel = '0;
        if (q.size() > 0 && q[0].cyc <= cyc) e = q.pop_front();
        compared++;
        if (e.cyc != cyc || bus.key_press !== e.press || bus.key_release !== e.rel) begin
          mismatched++;
          $display("FAIL pulse cyc=%0d got prs=%b rel=%b want cyc=%0d prs=%b rel=%b", cyc,
                   bus.key_press, bus.key_release, e.cyc, e.press, e.rel);
        end
      end
    end
  end
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.key_raw = 2'b11;
    hold(3);
    rst = 1'b0;
    hold(50);
    bus.key_raw[0] = 1'b0;
    hold(20);
    bus.key_raw[0] = 1'b1;
    hold(20);
    for (int i = 0; i < 40; i += 3) begin
      bus.key_raw[0] = ~bus.key_raw[0];
      hold(3);
    end
    bus.key_raw[0] = 1'b0;
    hold(20);
    bus.key_raw[0] = 1'b1;
    hold(20);
    bus.key_raw[0] = 1'b0;
    hold(20);
    bus.key_raw[0] = 1'b1;
    hold(20);
    bus.key_raw = 2'b00;
    hold(20);
    bus.key_raw = 2'b11;
    hold(20);
    bus.key_raw[1] = 1'b0;
    hold(20);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(20);
    bus.key_raw = 2'b11;
    hold(20);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 11) == 0) bus.key_raw[c] = ~bus.key_raw[c];
      rst = ($urandom_range(0, 599) == 0);
      hold(1);
    end
    rst = 1'b0;
    bus.key_raw = 2'b11;
    hold(30);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_events got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
